dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be, in order:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- TRANDATADDR  input  1  MEM-stage data access request (load or store).
- SORL  input  1  1 = store, 0 = load.
- SIZE  input  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- SIGNEXT  input  1  load result is sign-extended when 1, zero-extended when 0.
- DADDR  input  32  byte address of the access.
- DATAO  input  32  store data, right-aligned.
- FLUSH  input  1  discard the current access.
- DM_RDATA  input  32  memory read data.
- DM_ACK  input  1  memory completion strobe.
- DM_REQ  output  1  memory request; held high until acknowledged.
- DM_WE  output  1  memory write enable.
- DM_ADDR  output  32  word address: {DADDR[31:2], 2'b00}.
- DM_WSTRB  output  4  byte lane strobes.
- DM_WDATA  output  32  lane-replicated store data.
- MEMDATAI  output  32  aligned and extended load data for the MEM stage.
- MEMSTALL  output  1  freeze the pipeline.
- ADDRERR  output  1  misaligned access.
- BADVADDR  output  32  faulting address.

Function
REQ-003 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-004 In IDLE, a request SHALL start when TRANDATADDR=1, FLUSH=0 and the access is aligned.
- On the next edge the FSM SHALL move to WAIT.
- On the same edge it SHALL latch DM_ADDR, DM_WE=SORL, DM_WSTRB, DM_WDATA, the low address bits, SIZE and SIGNEXT.
REQ-005 Alignment rule: a halfword with DADDR[0]=1 is misaligned; a word with DADDR[1:0]!=00 is misaligned.
REQ-006 In IDLE with TRANDATADDR=1 and a misaligned address:
- ADDRERR=1 and BADVADDR=DADDR, both combinational.
- No memory request is issued, MEMSTALL=0, and the FSM stays in IDLE.
REQ-007 Store strobes (little-endian):
- byte: 0001 shifted left by DADDR[1:0];
- halfword: 0011 when DADDR[1]=0, 1100 when DADDR[1]=1;
- word: 1111.
REQ-008 Store data replication:
- byte: DATAO[7:0] copied to all four lanes;
- halfword: DATAO[15:0] copied to both halves;
- word: DATAO unchanged.
REQ-009 DM_REQ SHALL be 1 exactly while the FSM is in WAIT; DM_WE, DM_ADDR, DM_WSTRB and DM_WDATA SHALL stay stable for all of WAIT.
REQ-010 In WAIT, DM_ACK=1 SHALL move the FSM to DONE on that edge.
- For a load, the same edge SHALL register the lane selected by the latched address bits, extended according to SIZE and SIGNEXT, into MEMDATAI.
- A store SHALL leave MEMDATAI unchanged.
- There is no limit on WAIT length.
REQ-011 DM_ACK SHALL be ignored in IDLE and DONE.
REQ-012 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE; a request is never accepted in DONE.
REQ-013 MEMSTALL SHALL equal (IDLE and a request start condition per REQ-004) OR WAIT; it SHALL be 0 in DONE.
REQ-014 Latency:
- The request is seen in cycle 0 and DM_REQ is high from cycle 1.
- With DM_ACK in cycle k≥1, data is valid and MEMSTALL=0 in cycle k+1.
REQ-015 MEMDATAI SHALL hold its last loaded value in every cycle other than the load-completion update.
REQ-016 FLUSH behaviour:
- FLUSH in IDLE SHALL suppress the start.
- FLUSH during WAIT SHALL set an abort flag. The memory transaction still completes. On DM_ACK the FSM SHALL go directly to IDLE, MEMDATAI is not updated, and DONE is skipped.
- While the abort flag is set, MEMSTALL SHALL remain 1 until DM_ACK.

Reset
REQ-017 Reset SHALL apply asynchronously at any time, including mid-WAIT:
- the FSM goes to IDLE and the abort flag clears;
- DM_REQ, DM_WE, DM_WSTRB, DM_ADDR, DM_WDATA and MEMDATAI go to 0;
- combinational outputs follow from that state.
REQ-018 A DM_ACK arriving after reset for a transaction abandoned by reset SHALL be ignored.

Verification
REQ-019 Word load: DADDR=0x00001004, SIZE=10, DM_RDATA=0xDEADBEEF, DM_ACK in cycle 1 -> DM_ADDR=0x00001004, MEMSTALL=1 in cycles 0-1, MEMDATAI=0xDEADBEEF and MEMSTALL=0 in cycle 2.
REQ-020 Byte load, sign-extended: DADDR=0x...03, SIGNEXT=1, DM_RDATA=0x80112233 -> MEMDATAI=0xFFFFFF80. The same access with SIGNEXT=0 -> MEMDATAI=0x00000080.
REQ-021 Halfword store: DADDR=0x...02, DATAO=0x0000ABCD -> DM_WE=1, DM_WSTRB=1100, DM_WDATA=0xABCDABCD; MEMDATAI unchanged.
REQ-022 Misaligned word: DADDR=0x00000006, SIZE=10 -> ADDRERR=1, BADVADDR=0x00000006, DM_REQ stays 0, MEMSTALL=0.
REQ-023 Wait states plus flush: DM_ACK delayed 4 cycles and FLUSH pulsed in WAIT -> DM_REQ held 4 cycles, MEMSTALL=1 until the ACK, FSM returns to IDLE with no DONE, MEMDATAI unchanged.
REQ-024 Reset in WAIT, then DM_ACK=1 -> DM_REQ=0 immediately, FSM in IDLE, MEMDATAI=0 and unchanged by the stray ACK.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the MEM stage: alignment check, lane steering,
// a single outstanding request to memory, and load extraction. Latency: one cycle after DM_ACK.
module dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        TRANDATADDR,
  input  logic        SORL,
  input  logic [1:0]  SIZE,
  input  logic        SIGNEXT,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic        FLUSH,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [3:0]  DM_WSTRB,
  output logic [31:0] DM_WDATA,
  output logic [31:0] MEMDATAI,
  output logic        MEMSTALL,
  output logic        ADDRERR,
  output logic [31:0] BADVADDR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        abort_q, abort_d;
  logic [31:0] memdata_q, memdata_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        sext_q;

  logic        in_idle, misalign, start;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign in_idle  = (state_q == S_IDLE);
  assign misalign = ((SIZE == 2'b01) && DADDR[0]) || (SIZE[1] && (DADDR[1:0] != 2'b00));
  assign start    = in_idle && TRANDATADDR && !FLUSH && !misalign;

  always_comb begin
    strb_d  = 4'b1111;
    wdata_d = DATAO;
    case (SIZE)
      2'b00: begin
        strb_d  = 4'b0001 << DADDR[1:0];
        wdata_d = {4{DATAO[7:0]}};
      end
      2'b01: begin
        strb_d  = DADDR[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{DATAO[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset captured at request time, not the live DADDR.
  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = DM_RDATA[7:0];
      2'd1:    byte_sel = DM_RDATA[15:8];
      2'd2:    byte_sel = DM_RDATA[23:16];
      default: byte_sel = DM_RDATA[31:24];
    endcase
    half_sel = lo_q[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = DM_RDATA;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    memdata_d = memdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          abort_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (DM_ACK) begin
          abort_d = 1'b0;
          // A flush in the ack cycle itself counts as an abort too.
          if (abort_q || FLUSH) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!we_q) memdata_d = load_val;
          end
        end else if (FLUSH) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      abort_q   <= 1'b0;
      memdata_q <= 32'h0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      strb_q    <= 4'h0;
      wdata_q   <= 32'h0;
      lo_q      <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      abort_q   <= abort_d;
      memdata_q <= memdata_d;
      if (start) begin
        we_q    <= SORL;
        addr_q  <= {DADDR[31:2], 2'b00};
        strb_q  <= strb_d;
        wdata_q <= wdata_d;
        lo_q    <= DADDR[1:0];
        size_q  <= SIZE;
        sext_q  <= SIGNEXT;
      end
    end
  end

  assign DM_REQ   = (state_q == S_WAIT);
  assign DM_WE    = we_q;
  assign DM_ADDR  = addr_q;
  assign DM_WSTRB = strb_q;
  assign DM_WDATA = wdata_q;
  assign MEMDATAI = memdata_q;
  assign MEMSTALL = start || DM_REQ;
  assign ADDRERR  = in_idle && TRANDATADDR && misalign;
  assign BADVADDR = ADDRERR ? DADDR : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then random per-cycle stimulus.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        TRANDATADDR, SORL, SIGNEXT, FLUSH, DM_ACK;
  logic [1:0]  SIZE;
  logic [31:0] DADDR, DATAO, DM_RDATA;
  logic        DM_REQ, DM_WE, MEMSTALL, ADDRERR;
  logic [31:0] DM_ADDR, DM_WDATA, MEMDATAI, BADVADDR;
  logic [3:0]  DM_WSTRB;

  int tests = 0;
  int fails = 0;

  dmem_ctrl dut (
    .clk(clk), .reset(reset), .TRANDATADDR(TRANDATADDR), .SORL(SORL), .SIZE(SIZE),
    .SIGNEXT(SIGNEXT), .DADDR(DADDR), .DATAO(DATAO), .FLUSH(FLUSH), .DM_RDATA(DM_RDATA),
    .DM_ACK(DM_ACK), .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WSTRB(DM_WSTRB),
    .DM_WDATA(DM_WDATA), .MEMDATAI(MEMDATAI), .MEMSTALL(MEMSTALL), .ADDRERR(ADDRERR),
    .BADVADDR(BADVADDR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] rd, input int nb, input int off, input logic sx);
    logic [31:0] v, mask;
    if (nb == 4) return rd;
    mask = (nb == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * off)) & mask;
    if (sx && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Reference model: one outstanding transaction, a one-cycle completion gap.
  logic        m_pend, m_abort, m_done, m_load, m_sext;
  logic [31:0] m_addr, m_wdata, m_mem;
  logic [3:0]  m_strb;
  int          m_nb, m_off;

  initial begin
    logic idle, mis, start;
    int nb;
    m_pend = 0; m_abort = 0; m_done = 0; m_mem = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_pend = 0; m_abort = 0; m_done = 0; m_mem = 0;
        chk("rst_we", {31'b0, DM_WE}, 32'h0);
        chk("rst_addr", DM_ADDR, 32'h0);
        chk("rst_strb", {28'b0, DM_WSTRB}, 32'h0);
        chk("rst_wdata", DM_WDATA, 32'h0);
      end
      idle  = !m_pend && !m_done;
      nb    = nbytes(SIZE);
      mis   = (int'(DADDR[1:0]) % nb) != 0;
      start = idle && TRANDATADDR && !FLUSH && !mis;
      chk("req", {31'b0, DM_REQ}, {31'b0, m_pend});
      chk("stall", {31'b0, MEMSTALL}, {31'b0, start || m_pend});
      chk("addrerr", {31'b0, ADDRERR}, {31'b0, idle && TRANDATADDR && mis});
      if (idle && TRANDATADDR && mis) chk("badvaddr", BADVADDR, DADDR);
      chk("memdatai", MEMDATAI, m_mem);
      if (m_pend) begin
        chk("we", {31'b0, DM_WE}, {31'b0, !m_load});
        chk("addr", DM_ADDR, m_addr);
        chk("strb", {28'b0, DM_WSTRB}, {28'b0, m_strb});
        chk("wdata", DM_WDATA, m_wdata);
      end
      if (!reset) begin
        if (m_pend) begin
          if (FLUSH) m_abort = 1;
          if (DM_ACK) begin
            m_pend = 0;
            if (!m_abort) begin
              m_done = 1;
              if (m_load) m_mem = ext_load(DM_RDATA, m_nb, m_off, m_sext);
            end
            m_abort = 0;
          end
        end else if (m_done) begin
          m_done = 0;
        end else if (start) begin
          m_pend  = 1;
          m_abort = 0;
          m_load  = !SORL;
          m_sext  = SIGNEXT;
          m_nb    = nb;
          m_off   = int'(DADDR[1:0]);
          m_addr  = DADDR & 32'hFFFF_FFFC;
          m_strb  = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << m_off);
          m_wdata = (nb == 1) ? {24'b0, DATAO[7:0]} * 32'h0101_0101 :
                    (nb == 2) ? {16'b0, DATAO[15:0]} * 32'h0001_0001 : DATAO;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic tr, input logic sl, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d);
    TRANDATADDR = tr; SORL = sl; SIZE = sz; SIGNEXT = sx; DADDR = a; DATAO = d;
  endtask

  // Load/store with ack in WAIT cycle nwait; returns #1 into the cycle after the ack.
  task automatic acc(input logic sl, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd, input int nwait);
    set_req(1'b1, sl, sz, sx, a, d);
    DM_RDATA = rd;
    cyc();
    TRANDATADDR = 1'b0;
    for (int i = 1; i <= nwait; i++) begin
      DM_ACK = (i == nwait);
      cyc();
    end
    DM_ACK = 1'b0;
    #1;
  endtask

  initial begin
    int nreq;
    reset = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    FLUSH = 1'b0; DM_ACK = 1'b0; DM_RDATA = 32'h0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("reset_req", {31'b0, DM_REQ}, 32'h0);
    chk("reset_mem", MEMDATAI, 32'h0);
    cyc();

    // Word load, ack in cycle 1
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0);
    DM_RDATA = 32'hDEAD_BEEF;
    #1;
    chk("wl_stall0", {31'b0, MEMSTALL}, 32'h1);
    cyc();
    TRANDATADDR = 1'b0; DM_ACK = 1'b1;
    #1;
    chk("wl_addr", DM_ADDR, 32'h0000_1004);
    chk("wl_stall1", {31'b0, MEMSTALL}, 32'h1);
    cyc();
    DM_ACK = 1'b0;
    #1;
    chk("wl_data", MEMDATAI, 32'hDEAD_BEEF);
    chk("wl_stall2", {31'b0, MEMSTALL}, 32'h0);
    cyc();

    // Byte loads at offset 3, signed then unsigned
    acc(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h8011_2233, 1);
    chk("lb_sext", MEMDATAI, 32'hFFFF_FF80);
    cyc();
    acc(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h8011_2233, 2);
    chk("lb_zext", MEMDATAI, 32'h0000_0080);
    cyc();

    // Halfword store at offset 2
    set_req(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD);
    cyc();
    TRANDATADDR = 1'b0;
    #1;
    chk("sh_we", {31'b0, DM_WE}, 32'h1);
    chk("sh_strb", {28'b0, DM_WSTRB}, 32'hC);
    chk("sh_wdata", DM_WDATA, 32'hABCD_ABCD);
    DM_ACK = 1'b1;
    cyc();
    DM_ACK = 1'b0;
    #1;
    chk("sh_mem", MEMDATAI, 32'h0000_0080);
    cyc();

    // Misaligned word
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    #1;
    chk("mis_err", {31'b0, ADDRERR}, 32'h1);
    chk("mis_bad", BADVADDR, 32'h0000_0006);
    chk("mis_stall", {31'b0, MEMSTALL}, 32'h0);
    cyc();
    TRANDATADDR = 1'b0;
    #1;
    chk("mis_req", {31'b0, DM_REQ}, 32'h0);
    cyc();

    // Four wait cycles with a flush pulse, then an immediate new request
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    DM_RDATA = 32'h1234_5678;
    cyc();
    TRANDATADDR = 1'b0;
    nreq = 0;
    for (int i = 1; i <= 4; i++) begin
      DM_ACK = (i == 4);
      FLUSH  = (i == 2);
      #1;
      if (DM_REQ) nreq++;
      chk("fl_stall", {31'b0, MEMSTALL}, 32'h1);
      cyc();
    end
    DM_ACK = 1'b0; FLUSH = 1'b0;
    #1;
    chk("fl_reqcnt", nreq, 32'd4);
    chk("fl_req", {31'b0, DM_REQ}, 32'h0);
    chk("fl_mem", MEMDATAI, 32'h0000_0080);
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
    #1;
    chk("fl_nodone", {31'b0, MEMSTALL}, 32'h1);
    cyc();
    TRANDATADDR = 1'b0; DM_ACK = 1'b1;
    cyc();
    DM_ACK = 1'b0;
    #1;
    chk("fl_next", MEMDATAI, 32'h1234_5678);
    cyc();

    // Reset during WAIT, then a stray ack
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
    DM_RDATA = 32'hCAFE_F00D;
    cyc();
    TRANDATADDR = 1'b0;
    #1;
    chk("rw_req1", {31'b0, DM_REQ}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw_req0", {31'b0, DM_REQ}, 32'h0);
    chk("rw_mem0", MEMDATAI, 32'h0);
    cyc();
    reset = 1'b0; DM_ACK = 1'b1;
    cyc();
    DM_ACK = 1'b0;
    #1;
    chk("rw_stray", MEMDATAI, 32'h0);
    chk("rw_stall", {31'b0, MEMSTALL}, 32'h0);
    cyc();

    // Random per-cycle stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 79) == 0);
      TRANDATADDR = $urandom_range(0, 1) == 1;
      SORL        = $urandom_range(0, 1) == 1;
      SIZE        = 2'($urandom_range(0, 3));
      SIGNEXT     = $urandom_range(0, 1) == 1;
      DADDR       = $urandom();
      DATAO       = $urandom();
      DM_RDATA    = $urandom();
      FLUSH       = ($urandom_range(0, 7) == 0);
      DM_ACK      = ($urandom_range(0, 2) == 0);
      cyc();
    end
    reset = 1'b0; TRANDATADDR = 1'b0; FLUSH = 1'b0; DM_ACK = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
